// File: rtl/uart_tx.sv
// UART transmitter: request/acknowledge byte intake, 8 data bits LSB first,
// optional even/odd parity, one or two stop bits, CTS-gated frame start.
module uart_tx #(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic [7:0] usr_options,
    input  logic       tx_start,
    input  logic       cts_in,
    output logic       serial_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int DIV_9600   = CLK_FREQ / 9600;
    localparam int DIV_19200  = CLK_FREQ / 19200;
    localparam int DIV_57600  = CLK_FREQ / 57600;
    localparam int DIV_115200 = CLK_FREQ / 115200;
    localparam int CW = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] baud_cnt, baud_nxt;
    logic [CW-1:0] div_q, div_nxt, div_sel;
    logic [2:0]    bit_cnt, bit_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          par_en, par_en_nxt;
    logic          par_bit, par_bit_nxt;
    logic          stop_two, stop_two_nxt;
    logic          line_nxt;
    logic          accept;
    logic          bit_end;
    logic          unused_opts;

    assign unused_opts = ^usr_options[7:5];

    always_comb begin
        div_sel = CW'(DIV_9600);
        unique case (usr_options[4:3])
            2'b00: div_sel = CW'(DIV_9600);
            2'b01: div_sel = CW'(DIV_19200);
            2'b10: div_sel = CW'(DIV_57600);
            2'b11: div_sel = CW'(DIV_115200);
        endcase
    end

    assign accept  = tx_start & cts_in & ~tx_done;
    assign bit_end = (baud_cnt == '0);

    // serial_out is registered from this, so the line trails state by a clock
    always_comb begin
        state_nxt    = state;
        baud_nxt     = baud_cnt;
        div_nxt      = div_q;
        bit_nxt      = bit_cnt;
        shreg_nxt    = shreg;
        par_en_nxt   = par_en;
        par_bit_nxt  = par_bit;
        stop_two_nxt = stop_two;
        line_nxt     = 1'b1;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt    = START;
                    div_nxt      = div_sel;
                    baud_nxt     = div_sel - 1'b1;
                    bit_nxt      = '0;
                    shreg_nxt    = tx_data;
                    par_en_nxt   = ^usr_options[1:0];
                    par_bit_nxt  = (^tx_data) ^ usr_options[1];
                    stop_two_nxt = usr_options[2];
                end
            end
            START: begin
                line_nxt = 1'b0;
                if (bit_end) begin
                    state_nxt = DATA;
                    baud_nxt  = div_q - 1'b1;
                end else begin
                    baud_nxt = baud_cnt - 1'b1;
                end
            end
            DATA: begin
                line_nxt = shreg[0];
                if (bit_end) begin
                    baud_nxt  = div_q - 1'b1;
                    shreg_nxt = {1'b0, shreg[7:1]};
                    if (bit_cnt == 3'd7) begin
                        bit_nxt   = '0;
                        state_nxt = par_en ? PARITY : STOP;
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end else begin
                    baud_nxt = baud_cnt - 1'b1;
                end
            end
            PARITY: begin
                line_nxt = par_bit;
                if (bit_end) begin
                    state_nxt = STOP;
                    baud_nxt  = div_q - 1'b1;
                end else begin
                    baud_nxt = baud_cnt - 1'b1;
                end
            end
            STOP: begin
                line_nxt = 1'b1;
                if (bit_end) begin
                    if (stop_two && bit_cnt == 3'd0) begin
                        bit_nxt  = 3'd1;
                        baud_nxt = div_q - 1'b1;
                    end else begin
                        state_nxt = DONE;
                        bit_nxt   = '0;
                    end
                end else begin
                    baud_nxt = baud_cnt - 1'b1;
                end
            end
            DONE: begin
                if (!tx_start) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            div_q      <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_en     <= 1'b0;
            par_bit    <= 1'b0;
            stop_two   <= 1'b0;
            serial_out <= 1'b1;
        end else begin
            state      <= state_nxt;
            baud_cnt   <= baud_nxt;
            div_q      <= div_nxt;
            bit_cnt    <= bit_nxt;
            shreg      <= shreg_nxt;
            par_en     <= par_en_nxt;
            par_bit    <= par_bit_nxt;
            stop_two   <= stop_two_nxt;
            serial_out <= line_nxt;
        end
    end

    assign tx_busy = (state == START) || (state == DATA) ||
                     (state == PARITY) || (state == STOP);
    assign tx_done = (state == DONE);

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: driver queues expected frames,
// a line monitor decodes serial_out and compares bit by bit.
module tb_uart_tx;

    localparam int CLK_F = 5_000_000;

    typedef struct {
        int         div;
        int         nbits;
        logic [11:0] bits;
        logic       abortable;
    } frame_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic [7:0] usr_options;
    logic       tx_start;
    logic       cts_in;
    logic       serial_out;
    logic       tx_busy;
    logic       tx_done;

    frame_t sb[$];
    int     checks = 0;
    int     errors = 0;

    uart_tx #(.CLK_FREQ(CLK_F)) dut (
        .clock      (clk),
        .reset      (rst_n),
        .tx_data    (tx_data),
        .usr_options(usr_options),
        .tx_start   (tx_start),
        .cts_in     (cts_in),
        .serial_out (serial_out),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Line monitor: detects the start-bit fall, checks first and last
    // clock of every bit against the queued frame.
    initial begin
        logic   prev;
        frame_t f;
        logic   aborted;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && prev && !serial_out) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got start bit, expected idle at %0t", $time);
                end else begin
                    f = sb.pop_front();
                    aborted = 1'b0;
                    for (int k = 0; k < f.nbits * f.div; k++) begin
                        if (k > 0) @(negedge clk);
                        if (!rst_n) begin
                            aborted = 1'b1;
                            break;
                        end
                        if ((k % f.div == 0) || (k % f.div == f.div - 1))
                            chk_bit($sformatf("line_bit%0d", k / f.div),
                                    serial_out, f.bits[k / f.div]);
                    end
                    chk_bit("frame_abort", aborted, f.abortable);
                end
            end
            prev = serial_out;
        end
    end

    task automatic send(input logic [7:0] d, input logic [7:0] o,
                        input int div, input int nbits, input logic [11:0] bits,
                        input bit drop_early, input bit mid_change,
                        input bit release_rst);
        frame_t f;
        int     cyc;
        @(negedge clk);
        if (release_rst) rst_n = 1'b1;
        tx_data     = d;
        usr_options = o;
        cts_in      = 1'b1;
        tx_start    = 1'b1;
        f.div       = div;
        f.nbits     = nbits;
        f.bits      = bits;
        f.abortable = 1'b0;
        sb.push_back(f);
        @(posedge clk); #1;
        chk_bit("accept_busy", tx_busy, 1'b1);
        chk_bit("accept_line_high", serial_out, 1'b1);
        cyc = 1;
        @(posedge clk); #1;
        chk_bit("start_fall", serial_out, 1'b0);
        while (!tx_done && cyc < nbits * div + 20) begin
            if (drop_early && cyc == div) tx_start = 1'b0;
            if (mid_change && cyc == 3 * div) begin
                tx_data     = 8'hF0;
                usr_options = 8'h07;
                cts_in      = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk_int("done_latency", cyc, nbits * div);
        chk_bit("done_busy_low", tx_busy, 1'b0);
        if (drop_early) begin
            @(posedge clk); #1;
            chk_bit("done_pulse", tx_done, 1'b0);
        end else begin
            repeat (3) @(posedge clk);
            #1;
            chk_bit("done_held", tx_done, 1'b1);
            tx_start = 1'b0;
            @(posedge clk); #1;
            chk_bit("done_clear", tx_done, 1'b0);
        end
        cts_in = 1'b1;
    endtask

    task automatic abort_frame();
        frame_t f;
        @(negedge clk);
        tx_data     = 8'hF0;
        usr_options = 8'h10;
        cts_in      = 1'b1;
        tx_start    = 1'b1;
        f.div       = 86;
        f.nbits     = 10;
        f.bits      = 12'h3E0;
        f.abortable = 1'b1;
        sb.push_back(f);
        @(posedge clk);
        repeat (4 * 86 + 43) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_bit("abort_line", serial_out, 1'b1);
        chk_bit("abort_busy", tx_busy, 1'b0);
        chk_bit("abort_done", tx_done, 1'b0);
        tx_start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic cts_ok;
        rst_n       = 1'b0;
        tx_start    = 1'b1;
        cts_in      = 1'b1;
        tx_data     = 8'h55;
        usr_options = 8'h18;
        repeat (5) begin
            @(negedge clk);
            chk_bit("reset_line", serial_out, 1'b1);
            chk_bit("reset_busy", tx_busy, 1'b0);
            chk_bit("reset_done", tx_done, 1'b0);
        end

        send(8'h55, 8'h18, 43, 10, 12'h2AA, 1'b0, 1'b0, 1'b1);
        send(8'hA3, 8'h05, 520, 12, 12'hD46, 1'b0, 1'b0, 1'b0);
        send(8'hA3, 8'h06, 520, 12, 12'hF46, 1'b1, 1'b0, 1'b0);

        @(negedge clk);
        tx_data     = 8'h3C;
        usr_options = 8'h18;
        cts_in      = 1'b0;
        tx_start    = 1'b1;
        cts_ok      = 1'b1;
        repeat (1000) begin
            @(negedge clk);
            if (serial_out !== 1'b1 || tx_busy !== 1'b0) cts_ok = 1'b0;
        end
        chk_bit("cts_hold", cts_ok, 1'b1);
        send(8'h3C, 8'h18, 43, 10, 12'h278, 1'b0, 1'b0, 1'b0);

        send(8'h0F, 8'h10, 86, 10, 12'h21E, 1'b0, 1'b1, 1'b0);

        abort_frame();
        send(8'h81, 8'h19, 43, 11, 12'h502, 1'b0, 1'b0, 1'b0);

        repeat (20) @(negedge clk);
        chk_int("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
